// File: rtl/cpu_microcode_pkg.sv
// Shared CPU constants: sequencer state encodings, opcodes, instruction
// patterns and control-word bit positions used by the microcode stage.
package cpu_microcode_pkg;

  typedef enum logic [3:0] {
    STATE_FETCH_PC   = 4'd0,
    STATE_FETCH_INST = 4'd1,
    STATE_LOAD_ADDR  = 4'd2,
    STATE_RAM_B      = 4'd3,
    STATE_ALU_OP     = 4'd4,
    STATE_JUMP       = 4'd5,
    STATE_NEXT       = 4'd6,
    STATE_HALT       = 4'd7,
    STATE_OUT_A      = 4'd8,
    STATE_LDI        = 4'd9,
    STATE_MOV_FETCH  = 4'd10,
    STATE_MOV_LOAD   = 4'd11,
    STATE_MOV_STORE  = 4'd12
  } state_e;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_JMP = 8'h03;
  localparam logic [7:0] OP_JEZ = 8'h04;
  localparam logic [7:0] OP_JNZ = 8'h05;
  localparam logic [7:0] OP_OUT = 8'h06;
  localparam logic [7:0] OP_HLT = 8'h07;

  // Wildcard patterns ('?' bits are don't-care, compare with ==?).
  localparam logic [7:0] PATTERN_MOV = 8'b01??????;
  localparam logic [7:0] PATTERN_LDI = 8'b10000???;

  localparam int CTRL_PC_INC   = 0;
  localparam int CTRL_PC_OUT   = 1;
  localparam int CTRL_PC_LOAD  = 2;
  localparam int CTRL_MAR_LOAD = 3;
  localparam int CTRL_RAM_OUT  = 4;
  localparam int CTRL_RAM_IN   = 5;
  localparam int CTRL_IR_LOAD  = 6;
  localparam int CTRL_A_LOAD   = 7;
  localparam int CTRL_A_OUT    = 8;
  localparam int CTRL_B_LOAD   = 9;
  localparam int CTRL_ALU_OUT  = 10;
  localparam int CTRL_ALU_SUB  = 11;
  localparam int CTRL_OUT_LOAD = 12;
  localparam int CTRL_REG_OE   = 13;
  localparam int CTRL_REG_WE   = 14;
  localparam int CTRL_TMP_LOAD = 15;
  localparam int CTRL_TMP_OUT  = 16;

endpackage

// File: rtl/cpu_microcode_rom.sv
// Combinational microcode table: maps sequencer state, opcode and the stored
// zero flag to the control word and register select for the next cycle.
// Ports:
//   state_i     - current sequencer state
//   opcode_i    - instruction register contents
//   zero_flag_i - stored zero flag (conditional jump decision)
//   ctrl_o      - control word to be registered
//   reg_sel_o   - register-file select to be registered
module cpu_microcode_rom
  import cpu_microcode_pkg::*;
#(
  parameter int CTRL_W = 17,
  parameter int SEL_W  = 3
) (
  input  logic [3:0]        state_i,
  input  logic [7:0]        opcode_i,
  input  logic              zero_flag_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [SEL_W-1:0]  reg_sel_o
);

  logic jump_taken;

  always_comb begin
    jump_taken = (opcode_i == OP_JMP) ||
                 ((opcode_i == OP_JEZ) &&  zero_flag_i) ||
                 ((opcode_i == OP_JNZ) && !zero_flag_i);
  end

  always_comb begin
    ctrl_o    = '0;
    reg_sel_o = '0;
    case (state_i)
      STATE_FETCH_PC: begin
        ctrl_o[CTRL_PC_OUT]   = 1'b1;
        ctrl_o[CTRL_MAR_LOAD] = 1'b1;
      end
      STATE_FETCH_INST: begin
        ctrl_o[CTRL_RAM_OUT]  = 1'b1;
        ctrl_o[CTRL_IR_LOAD]  = 1'b1;
        ctrl_o[CTRL_PC_INC]   = 1'b1;
      end
      STATE_LOAD_ADDR: begin
        ctrl_o[CTRL_RAM_OUT]  = 1'b1;
        ctrl_o[CTRL_MAR_LOAD] = 1'b1;
        ctrl_o[CTRL_PC_INC]   = 1'b1;
      end
      STATE_RAM_B: begin
        ctrl_o[CTRL_RAM_OUT]  = 1'b1;
        ctrl_o[CTRL_B_LOAD]   = 1'b1;
      end
      STATE_ALU_OP: begin
        ctrl_o[CTRL_ALU_OUT]  = 1'b1;
        ctrl_o[CTRL_A_LOAD]   = 1'b1;
        ctrl_o[CTRL_ALU_SUB]  = (opcode_i == OP_SUB);
      end
      STATE_JUMP: begin
        // The jump operand is always read from RAM; a not-taken jump just
        // steps the PC past it.
        ctrl_o[CTRL_RAM_OUT]  = 1'b1;
        ctrl_o[CTRL_PC_LOAD]  = jump_taken;
        ctrl_o[CTRL_PC_INC]   = !jump_taken;
      end
      STATE_LDI: begin
        ctrl_o[CTRL_RAM_OUT]  = 1'b1;
        ctrl_o[CTRL_REG_WE]   = 1'b1;
        ctrl_o[CTRL_PC_INC]   = 1'b1;
        reg_sel_o             = opcode_i[SEL_W-1:0];
      end
      STATE_MOV_LOAD: begin
        ctrl_o[CTRL_REG_OE]   = 1'b1;
        ctrl_o[CTRL_TMP_LOAD] = 1'b1;
        reg_sel_o             = opcode_i[SEL_W-1:0];
      end
      STATE_MOV_STORE: begin
        ctrl_o[CTRL_TMP_OUT]  = 1'b1;
        ctrl_o[CTRL_REG_WE]   = 1'b1;
        reg_sel_o             = opcode_i[2*SEL_W-1:SEL_W];
      end
      STATE_OUT_A: begin
        ctrl_o[CTRL_A_OUT]    = 1'b1;
        ctrl_o[CTRL_OUT_LOAD] = 1'b1;
      end
      // MOV_FETCH, NEXT, HALT and undefined codes leave the bus idle.
      default: begin
        ctrl_o    = '0;
        reg_sel_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_microcode.sv
// Microcode stage of the CPU: registers the control word and register select
// for the current sequencer state, and owns the sticky halt latch, the zero
// flag used by conditional jumps and the reset_cycle pulse to the sequencer.
// Ports:
//   clk         - system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   state       - current sequencer state
//   opcode      - instruction register contents
//   alu_zero    - ALU result-is-zero indication
//   ctrl        - registered control word
//   reg_sel     - registered register-file select
//   zero_flag   - stored zero flag
//   halt        - sticky halt / clock-stop request
//   reset_cycle - one-clock pulse restarting the sequencer cycle count
module cpu_microcode
  import cpu_microcode_pkg::*;
#(
  parameter int CTRL_W = 17,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        state,
  input  logic [7:0]        opcode,
  input  logic              alu_zero,
  output logic [CTRL_W-1:0] ctrl,
  output logic [SEL_W-1:0]  reg_sel,
  output logic              zero_flag,
  output logic              halt,
  output logic              reset_cycle
);

  logic [CTRL_W-1:0] rom_ctrl;
  logic [SEL_W-1:0]  rom_sel;

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [SEL_W-1:0]  reg_sel_q, reg_sel_d;
  logic              zero_flag_q, zero_flag_d;
  logic              halt_q, halt_d;
  logic              reset_cycle_q, reset_cycle_d;

  cpu_microcode_rom #(
    .CTRL_W (CTRL_W),
    .SEL_W  (SEL_W)
  ) u_rom (
    .state_i     (state),
    .opcode_i    (opcode),
    .zero_flag_i (zero_flag_q),
    .ctrl_o      (rom_ctrl),
    .reg_sel_o   (rom_sel)
  );

  always_comb begin
    ctrl_d        = rom_ctrl;
    reg_sel_d     = rom_sel;
    reset_cycle_d = (state == STATE_NEXT);
    halt_d        = halt_q | (state == STATE_HALT);
    zero_flag_d   = zero_flag_q;
    // The flag captures the ALU result while the ALU is driving the bus,
    // i.e. while the registered word currently has alu_out asserted.
    if (ctrl_q[CTRL_ALU_OUT]) begin
      zero_flag_d = alu_zero;
    end
    // Once halted everything is parked until reset.
    if (halt_q) begin
      ctrl_d        = '0;
      reg_sel_d     = '0;
      reset_cycle_d = 1'b0;
      zero_flag_d   = zero_flag_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q        <= '0;
      reg_sel_q     <= '0;
      zero_flag_q   <= 1'b0;
      halt_q        <= 1'b0;
      reset_cycle_q <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      reg_sel_q     <= reg_sel_d;
      zero_flag_q   <= zero_flag_d;
      halt_q        <= halt_d;
      reset_cycle_q <= reset_cycle_d;
    end
  end

  assign ctrl        = ctrl_q;
  assign reg_sel     = reg_sel_q;
  assign zero_flag   = zero_flag_q;
  assign halt        = halt_q;
  assign reset_cycle = reset_cycle_q;

endmodule

// File: tb/tb_cpu_microcode.sv
// Scoreboard bench for cpu_microcode: each step pushes the expected output
// set when the inputs are driven and pops/compares it one edge later.
module tb_cpu_microcode;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  state;
  logic [7:0]  opcode;
  logic        alu_zero;
  logic [16:0] ctrl;
  logic [2:0]  reg_sel;
  logic        zero_flag;
  logic        halt;
  logic        reset_cycle;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [16:0] c;
    logic [2:0]  sel;
    logic        zf;
    logic        hlt;
    logic        rc;
  } obs_t;

  typedef struct packed {
    logic [3:0] st;
    logic [7:0] op;
    logic       az;
    obs_t       e;
  } step_t;

  obs_t sb[$];

  cpu_microcode #(.CTRL_W(17), .SEL_W(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .state       (state),
    .opcode      (opcode),
    .alu_zero    (alu_zero),
    .ctrl        (ctrl),
    .reg_sel     (reg_sel),
    .zero_flag   (zero_flag),
    .halt        (halt),
    .reset_cycle (reset_cycle)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.c = ctrl; o.sel = reg_sel; o.zf = zero_flag; o.hlt = halt; o.rc = reset_cycle;
    return o;
  endfunction

  function automatic obs_t mk(input logic [16:0] c, input logic [2:0] sel,
                              input logic zf, input logic hlt, input logic rc);
    obs_t o;
    o.c = c; o.sel = sel; o.zf = zf; o.hlt = hlt; o.rc = rc;
    return o;
  endfunction

  function automatic step_t stp(input logic [3:0] st, input logic [7:0] op,
                                input logic az, input obs_t e);
    step_t s;
    s.st = st; s.op = op; s.az = az; s.e = e;
    return s;
  endfunction

  // Drive one state at the falling edge and queue what the outputs must be
  // just after the following rising edge.
  task automatic drive(input step_t s);
    @(negedge clk);
    state = s.st; opcode = s.op; alu_zero = s.az;
    sb.push_back(s.e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    reset_n = 1'b0; state = 4'd0; opcode = 8'h00; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(17'h0, 3'd0, 1'b0, 1'b0, 1'b0));
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_initial: got %h expected %h", got, exp);
    end
    @(negedge clk); reset_n = 1'b1;
    drive(stp(4'd1, 8'h00, 1'b0, mk(17'h00051, 3'd0, 1'b0, 1'b0, 1'b0)));
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_prerun: got %h expected %h", got, exp);
    end
    // Assert reset between clock edges: outputs must clear immediately.
    #2 reset_n = 1'b0;
    #1;
    sb.push_back(mk(17'h0, 3'd0, 1'b0, 1'b0, 1'b0));
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", got, exp);
    end
    @(negedge clk); reset_n = 1'b1;
    drive(stp(4'd0, 8'h00, 1'b0, mk(17'h0000A, 3'd0, 1'b0, 1'b0, 1'b0)));
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_alu_jump();
    step_t tbl[$];
    obs_t got, exp;
    tbl.push_back(stp(4'd0, 8'h02, 1'b0, mk(17'h0000A, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd1, 8'h02, 1'b0, mk(17'h00051, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd0, 8'h02, 1'b0, mk(17'h0000A, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd2, 8'h02, 1'b0, mk(17'h00019, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd3, 8'h02, 1'b0, mk(17'h00210, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd4, 8'h02, 1'b1, mk(17'h00C80, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd0, 8'h02, 1'b1, mk(17'h0000A, 3'd0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd5, 8'h04, 1'b0, mk(17'h00014, 3'd0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd5, 8'h05, 1'b0, mk(17'h00011, 3'd0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd5, 8'h03, 1'b0, mk(17'h00014, 3'd0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd4, 8'h01, 1'b0, mk(17'h00480, 3'd0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd0, 8'h01, 1'b0, mk(17'h0000A, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd5, 8'h05, 1'b1, mk(17'h00014, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd5, 8'h04, 1'b1, mk(17'h00011, 3'd0, 1'b0, 1'b0, 1'b0)));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL alu_jump step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_misc_states();
    step_t tbl[$];
    obs_t got, exp;
    tbl.push_back(stp(4'd8,  8'h06, 1'b0, mk(17'h01100, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd9,  8'h85, 1'b0, mk(17'h04011, 3'd5, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd10, 8'h5D, 1'b0, mk(17'h00000, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd11, 8'h5D, 1'b0, mk(17'h0A000, 3'd5, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd12, 8'h5D, 1'b0, mk(17'h14000, 3'd3, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd13, 8'hFF, 1'b1, mk(17'h00000, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd15, 8'h5D, 1'b1, mk(17'h00000, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd1,  8'h5D, 1'b0, mk(17'h00051, 3'd0, 1'b0, 1'b0, 1'b0)));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL misc_states step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t tbl[$];
    obs_t got, exp;
    tbl.push_back(stp(4'd6, 8'h00, 1'b0, mk(17'h00000, 3'd0, 1'b0, 1'b0, 1'b1)));
    tbl.push_back(stp(4'd0, 8'h00, 1'b0, mk(17'h0000A, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd6, 8'h00, 1'b0, mk(17'h00000, 3'd0, 1'b0, 1'b0, 1'b1)));
    tbl.push_back(stp(4'd6, 8'h00, 1'b0, mk(17'h00000, 3'd0, 1'b0, 1'b0, 1'b1)));
    tbl.push_back(stp(4'd0, 8'h00, 1'b0, mk(17'h0000A, 3'd0, 1'b0, 1'b0, 1'b0)));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_halt();
    step_t tbl[$];
    obs_t got, exp;
    tbl.push_back(stp(4'd4, 8'h02, 1'b0, mk(17'h00C80, 3'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(stp(4'd7, 8'h07, 1'b1, mk(17'h00000, 3'd0, 1'b1, 1'b1, 1'b0)));
    tbl.push_back(stp(4'd0, 8'h02, 1'b0, mk(17'h00000, 3'd0, 1'b1, 1'b1, 1'b0)));
    tbl.push_back(stp(4'd4, 8'h02, 1'b0, mk(17'h00000, 3'd0, 1'b1, 1'b1, 1'b0)));
    tbl.push_back(stp(4'd0, 8'h02, 1'b0, mk(17'h00000, 3'd0, 1'b1, 1'b1, 1'b0)));
    tbl.push_back(stp(4'd6, 8'h00, 1'b1, mk(17'h00000, 3'd0, 1'b1, 1'b1, 1'b0)));
    tbl.push_back(stp(4'd9, 8'h85, 1'b0, mk(17'h00000, 3'd0, 1'b1, 1'b1, 1'b0)));
    foreach (tbl[i]) begin
      drive(tbl[i]);
      got = sample(); exp = sb.pop_front(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL halt step %0d: got %h expected %h", i, got, exp);
      end
    end
    #2 reset_n = 1'b0;
    #1;
    sb.push_back(mk(17'h0, 3'd0, 1'b0, 1'b0, 1'b0));
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL halt_reset: got %h expected %h", got, exp);
    end
    @(negedge clk); reset_n = 1'b1;
    drive(stp(4'd0, 8'h00, 1'b0, mk(17'h0000A, 3'd0, 1'b0, 1'b0, 1'b0)));
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL halt_release: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_reset_vs_halt();
    obs_t got, exp;
    @(negedge clk); reset_n = 1'b0;
    drive(stp(4'd7, 8'h07, 1'b0, mk(17'h0, 3'd0, 1'b0, 1'b0, 1'b0)));
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_wins: got %h expected %h", got, exp);
    end
    reset_n = 1'b1;
    drive(stp(4'd0, 8'h00, 1'b0, mk(17'h0000A, 3'd0, 1'b0, 1'b0, 1'b0)));
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL after_reset_wins: got %h expected %h", got, exp);
    end
    drive(stp(4'd7, 8'h07, 1'b0, mk(17'h0, 3'd0, 1'b0, 1'b1, 1'b0)));
    got = sample(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL halt_again: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_alu_jump();
    test_misc_states();
    test_back_to_back();
    test_halt();
    test_reset_vs_halt();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
